// File: rtl/lvds_align_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lvds_align_ctrl_if
// Description : Bundle of the sync-channel word stream, training control and
//               alignment status signals of the LVDS word-alignment controller.
//               master : word source and status consumer (deserializer side)
//               slave  : alignment controller
//   sync_word   [9:0]  deserialized sync-channel word
//   word_valid         one-cycle strobe per deserialized word
//   train_start        one-cycle pulse, (re)starts training
//   slip_offset [3:0]  word-boundary bit offset, 0..9
//   aligned            high while locked
//   align_fail         high while training has failed
//   frame_start        one-cycle frame-start pulse
//   line_start         one-cycle line-start pulse
//   state_dbg   [2:0]  encoded controller state
// Revision    : 1.0 - initial release
// ============================================================================
interface lvds_align_ctrl_if;
    logic [9:0] sync_word;
    logic       word_valid;
    logic       train_start;
    logic [3:0] slip_offset;
    logic       aligned;
    logic       align_fail;
    logic       frame_start;
    logic       line_start;
    logic [2:0] state_dbg;

    modport master (
        output sync_word, word_valid, train_start,
        input  slip_offset, aligned, align_fail, frame_start, line_start,
               state_dbg
    );

    modport slave (
        input  sync_word, word_valid, train_start,
        output slip_offset, aligned, align_fail, frame_start, line_start,
               state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/lvds_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lvds_align_ctrl
// Description : Word-alignment training controller for the 4-data + 1-sync
//               LVDS receiver. Steps the deserializer bit offset until the
//               sync channel shows the training word repeatedly, declares
//               lock, monitors for loss of alignment and decodes frame/line
//               start codes into single-cycle pulses.
// Ports       : clk_input  - word-domain clock
//               reset_n    - asynchronous active-low reset
//               bus        - lvds_align_ctrl_if.slave (word stream in,
//                            offset / status / sync pulses out)
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_align_ctrl #(
    parameter logic [9:0]  TRAIN_PATTERN    = 10'h3A6,
    parameter logic [9:0]  FRAME_START_CODE = 10'h2AA,
    parameter logic [9:0]  LINE_START_CODE  = 10'h0AA,
    parameter int unsigned LOCK_COUNT       = 16,
    parameter int unsigned SETTLE_WORDS     = 4,
    parameter int unsigned LOSS_COUNT       = 8,
    parameter int unsigned MAX_SLIPS        = 20
) (
    input  wire              clk_input,
    input  wire              reset_n,
    lvds_align_ctrl_if.slave bus
);

    localparam logic [7:0] c_lock_cnt   = 8'(LOCK_COUNT);
    localparam logic [7:0] c_settle_cnt = 8'(SETTLE_WORDS);
    localparam logic [7:0] c_loss_cnt   = 8'(LOSS_COUNT);
    localparam logic [7:0] c_max_slips  = 8'(MAX_SLIPS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CHECK  = 3'd2,
        SLIP   = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } state_t;

    state_t     state_q,       state_d;
    logic [3:0] slip_offset_q, slip_offset_d;
    logic [7:0] slip_cnt_q,    slip_cnt_d;
    logic [7:0] match_cnt_q,   match_cnt_d;
    logic [7:0] settle_cnt_q,  settle_cnt_d;
    logic [7:0] err_cnt_q,     err_cnt_d;
    logic       aligned_q,     aligned_d;
    logic       align_fail_q,  align_fail_d;
    logic       frame_start_q, frame_start_d;
    logic       line_start_q,  line_start_d;

    // Counters stop at all-ones so the >= thresholds can never be missed.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        slip_offset_d = slip_offset_q;
        slip_cnt_d    = slip_cnt_q;
        match_cnt_d   = match_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        err_cnt_d     = err_cnt_q;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;

        if (bus.train_start) begin
            // Restart overrides whatever the current word would have done.
            state_d       = SETTLE;
            slip_offset_d = 4'd0;
            slip_cnt_d    = 8'd0;
            match_cnt_d   = 8'd0;
            settle_cnt_d  = 8'd0;
            err_cnt_d     = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: ;

                SETTLE: begin
                    if (bus.word_valid) begin
                        settle_cnt_d = sat_inc(settle_cnt_q);
                        if (settle_cnt_d >= c_settle_cnt) begin
                            state_d      = CHECK;
                            settle_cnt_d = 8'd0;
                            match_cnt_d  = 8'd0;
                        end
                    end
                end

                CHECK: begin
                    if (bus.word_valid) begin
                        if (bus.sync_word == TRAIN_PATTERN) begin
                            match_cnt_d = sat_inc(match_cnt_q);
                            if (match_cnt_d >= c_lock_cnt) begin
                                state_d   = LOCKED;
                                err_cnt_d = 8'd0;
                            end
                        end else begin
                            state_d = SLIP;
                        end
                    end
                end

                SLIP: begin
                    slip_offset_d = (slip_offset_q >= 4'd9) ? 4'd0
                                                            : slip_offset_q + 4'd1;
                    slip_cnt_d    = sat_inc(slip_cnt_q);
                    settle_cnt_d  = 8'd0;
                    state_d       = (slip_cnt_d >= c_max_slips) ? FAIL : SETTLE;
                end

                LOCKED: begin
                    if (bus.word_valid) begin
                        if (bus.sync_word == TRAIN_PATTERN) begin
                            err_cnt_d = 8'd0;
                        end else if (bus.sync_word == FRAME_START_CODE) begin
                            frame_start_d = 1'b1;
                            err_cnt_d     = 8'd0;
                        end else if (bus.sync_word == LINE_START_CODE) begin
                            line_start_d = 1'b1;
                            err_cnt_d    = 8'd0;
                        end else begin
                            err_cnt_d = sat_inc(err_cnt_q);
                            if (err_cnt_d >= c_loss_cnt) begin
                                // Retrain from the current offset with a
                                // fresh slip budget.
                                state_d      = SETTLE;
                                err_cnt_d    = 8'd0;
                                slip_cnt_d   = 8'd0;
                                settle_cnt_d = 8'd0;
                            end
                        end
                    end
                end

                FAIL: ;

                default: state_d = IDLE;
            endcase
        end

        // Status flags follow the state being entered so they appear
        // together with state_dbg.
        aligned_d    = (state_d == LOCKED);
        align_fail_d = (state_d == FAIL);
    end

    always_ff @(posedge clk_input or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            slip_offset_q <= 4'd0;
            slip_cnt_q    <= 8'd0;
            match_cnt_q   <= 8'd0;
            settle_cnt_q  <= 8'd0;
            err_cnt_q     <= 8'd0;
            aligned_q     <= 1'b0;
            align_fail_q  <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            slip_offset_q <= slip_offset_d;
            slip_cnt_q    <= slip_cnt_d;
            match_cnt_q   <= match_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            err_cnt_q     <= err_cnt_d;
            aligned_q     <= aligned_d;
            align_fail_q  <= align_fail_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign bus.slip_offset = slip_offset_q;
    assign bus.aligned     = aligned_q;
    assign bus.align_fail  = align_fail_q;
    assign bus.frame_start = frame_start_q;
    assign bus.line_start  = line_start_q;
    assign bus.state_dbg   = state_q;

endmodule
`default_nettype wire
